// File: rtl/core_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Holds the fetch FSM encoding, reset defaults and the PC alignment helper.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        DROP  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_INCR       = 32'd4;

    // Redirect targets are always word aligned; low two bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_out_buf.sv
// One-entry IF/ID buffer: registered instruction/PC with valid flag, updated on the clock edge.
// Flush beats load beats consume; if_instr reads as NOP_INSTR whenever the entry is empty.
module fetch_out_buf
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_consume,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc
);

    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc    <= RESET_PC;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (r_valid && i_consume) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_valid ? r_instr : NOP_INSTR;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns fetch PC, issues one imem request at a time, squashes wrong-path responses.
// Requests only when the output buffer will be free; redirect takes effect on the next edge.
module fetch_ctrl
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        flush
);

    fetch_state_e r_state, w_state_nxt;
    logic [31:0]  r_fetch_pc, w_fetch_pc_nxt;
    logic [31:0]  r_req_pc, w_req_pc_nxt;
    logic         w_req;
    logic         w_hs;
    logic         w_load;
    logic [31:0]  w_redirect_pc;

    assign w_redirect_pc = align_pc(redirect_pc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_req_pc   <= w_req_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_req_pc_nxt   = r_req_pc;
        w_load         = 1'b0;
        // Requesting only with a free (or draining) buffer means a response can always be loaded.
        w_req          = (r_state == FETCH) && (!if_valid || id_ready);
        w_hs           = w_req && imem_gnt;

        if (redirect) begin
            w_fetch_pc_nxt = w_redirect_pc;
        end

        case (r_state)
            IDLE: begin
                w_state_nxt = FETCH;
            end
            FETCH: begin
                if (w_hs) begin
                    if (redirect) begin
                        w_state_nxt = DROP;
                    end else begin
                        w_req_pc_nxt   = r_fetch_pc;
                        w_fetch_pc_nxt = r_fetch_pc + PC_INCR;
                        w_state_nxt    = WAIT;
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    w_load      = !redirect;
                    w_state_nxt = FETCH;
                end else if (redirect) begin
                    w_state_nxt = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    w_state_nxt = FETCH;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    fetch_out_buf #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_consume (id_ready),
        .i_flush   (redirect),
        .i_instr   (imem_rdata),
        .i_pc      (r_req_pc),
        .o_valid   (if_valid),
        .o_instr   (if_instr),
        .o_pc      (if_pc)
    );

    assign imem_req  = w_req;
    assign imem_addr = r_fetch_pc;
    assign flush     = redirect;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed cycle-by-cycle vectors for fetch_ctrl plus a hand sequence for reset mid-request.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] A0  = 32'h1111_0001;
    localparam logic [31:0] A1  = 32'h2222_0002;
    localparam logic [31:0] A2  = 32'h3333_0003;
    localparam logic [31:0] A3  = 32'h4444_0004;
    localparam logic [31:0] A4  = 32'h5555_0005;
    localparam logic [31:0] A5  = 32'h6666_0006;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .id_ready    (id_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .flush       (flush)
    );

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_flush;
    } vec_t;

    vec_t vt[27];

    function automatic vec_t mk(input logic gnt, input logic rv, input logic [31:0] rdata,
                                input logic rdy, input logic redir, input logic [31:0] rpc,
                                input logic e_req, input logic [31:0] e_addr, input logic e_vld,
                                input logic [31:0] e_pc, input logic [31:0] e_instr,
                                input logic e_flush);
        vec_t v;
        v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc = e_pc;
        v.e_instr = e_instr; v.e_flush = e_flush;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic gnt, input logic rv, input logic [31:0] rdata,
                         input logic rdy, input logic redir, input logic [31:0] rpc);
        imem_gnt    = gnt;
        imem_rvalid = rv;
        imem_rdata  = rdata;
        id_ready    = rdy;
        redirect    = redir;
        redirect_pc = rpc;
    endtask

    task automatic check_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                              input logic e_vld, input logic [31:0] e_pc,
                              input logic [31:0] e_instr, input logic e_flush);
        chk({tag, ".req"},   {31'd0, imem_req}, {31'd0, e_req});
        chk({tag, ".addr"},  imem_addr,          e_addr);
        chk({tag, ".vld"},   {31'd0, if_valid},  {31'd0, e_vld});
        chk({tag, ".pc"},    if_pc,              e_pc);
        chk({tag, ".instr"}, if_instr,           e_instr);
        chk({tag, ".flush"}, {31'd0, flush},     {31'd0, e_flush});
    endtask

    initial begin
        // Cycle 1 is the first cycle after reset release (IDLE).
        //            gnt rv rdata rdy rd rpc            req addr           vld pc             instr fl
        vt[0]  = mk(1, 0, 0,   1, 0, 0,             0, 32'h0,          0, 32'h0,          0,  0);
        vt[1]  = mk(1, 0, 0,   1, 0, 0,             1, 32'h0,          0, 32'h0,          0,  0);
        vt[2]  = mk(0, 1, A0,  1, 0, 0,             0, 32'h4,          0, 32'h0,          0,  0);
        vt[3]  = mk(1, 0, 0,   1, 0, 0,             1, 32'h4,          1, 32'h0,          A0, 0);
        vt[4]  = mk(0, 1, A1,  1, 0, 0,             0, 32'h8,          0, 32'h0,          0,  0);
        vt[5]  = mk(1, 0, 0,   0, 0, 0,             0, 32'h8,          1, 32'h4,          A1, 0);
        vt[6]  = mk(1, 0, 0,   0, 0, 0,             0, 32'h8,          1, 32'h4,          A1, 0);
        vt[7]  = mk(1, 0, 0,   1, 0, 0,             1, 32'h8,          1, 32'h4,          A1, 0);
        vt[8]  = mk(0, 0, 0,   1, 0, 0,             0, 32'hC,          0, 32'h4,          0,  0);
        vt[9]  = mk(0, 0, 0,   1, 1, 32'h103,       0, 32'hC,          0, 32'h4,          0,  1);
        vt[10] = mk(0, 0, 0,   1, 0, 0,             0, 32'h100,        0, 32'h4,          0,  0);
        vt[11] = mk(0, 1, BAD, 1, 0, 0,             0, 32'h100,        0, 32'h4,          0,  0);
        vt[12] = mk(0, 0, 0,   1, 0, 0,             1, 32'h100,        0, 32'h4,          0,  0);
        vt[13] = mk(1, 0, 0,   1, 0, 0,             1, 32'h100,        0, 32'h4,          0,  0);
        vt[14] = mk(0, 1, A2,  1, 0, 0,             0, 32'h104,        0, 32'h4,          0,  0);
        vt[15] = mk(1, 0, 0,   1, 1, 32'h200,       1, 32'h104,        1, 32'h100,        A2, 1);
        vt[16] = mk(0, 1, BAD, 1, 0, 0,             0, 32'h200,        0, 32'h100,        0,  0);
        vt[17] = mk(1, 0, 0,   0, 0, 0,             1, 32'h200,        0, 32'h100,        0,  0);
        vt[18] = mk(0, 1, A3,  0, 0, 0,             0, 32'h204,        0, 32'h100,        0,  0);
        vt[19] = mk(0, 0, 0,   0, 0, 0,             0, 32'h204,        1, 32'h200,        A3, 0);
        vt[20] = mk(0, 0, 0,   0, 1, 32'h300,       0, 32'h204,        1, 32'h200,        A3, 1);
        vt[21] = mk(1, 0, 0,   1, 0, 0,             1, 32'h300,        0, 32'h200,        0,  0);
        vt[22] = mk(0, 1, BAD, 1, 1, 32'hFFFF_FFFC, 0, 32'h304,        0, 32'h200,        0,  1);
        vt[23] = mk(1, 0, 0,   1, 0, 0,             1, 32'hFFFF_FFFC,  0, 32'h200,        0,  0);
        vt[24] = mk(0, 1, A4,  1, 0, 0,             0, 32'h0,          0, 32'h200,        0,  0);
        vt[25] = mk(0, 0, 0,   0, 0, 0,             0, 32'h0,          1, 32'hFFFF_FFFC,  A4, 0);
        vt[26] = mk(1, 0, 0,   1, 0, 0,             1, 32'h0,          1, 32'hFFFF_FFFC,  A4, 0);

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_outs("reset", 0, 32'h0, 0, 32'h0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 27; i++) begin
            drive(vt[i].gnt, vt[i].rv, vt[i].rdata, vt[i].rdy, vt[i].redir, vt[i].rpc);
            #1;
            check_outs($sformatf("vec%0d", i + 1), vt[i].e_req, vt[i].e_addr, vt[i].e_vld,
                       vt[i].e_pc, vt[i].e_instr, vt[i].e_flush);
            @(negedge clk);
        end

        // Reset while a request to 0x0 is outstanding, then a stale response arrives.
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check_outs("midrst", 0, 32'h0, 0, 32'h0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1, BAD, 1, 0, 0);
        #1;
        check_outs("stale_idle", 0, 32'h0, 0, 32'h0, 0, 0);
        @(negedge clk);
        drive(0, 1, BAD, 1, 0, 0);
        #1;
        check_outs("stale_fetch", 1, 32'h0, 0, 32'h0, 0, 0);
        @(negedge clk);
        drive(1, 0, 0, 1, 0, 0);
        #1;
        check_outs("restart_hs", 1, 32'h0, 0, 32'h0, 0, 0);
        @(negedge clk);
        drive(0, 1, A5, 0, 0, 0);
        #1;
        check_outs("restart_wait", 0, 32'h4, 0, 32'h0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check_outs("restart_load", 0, 32'h4, 1, 32'h0, A5, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
